// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping stage: MM:SS BCD count (00:00..59:59) with run/pause
// control and a 2 Hz adjust mode that steps either the seconds or the minutes.
// Optional build macro STOPWATCH_SATURATE_EN: hold at 59:59 and pause instead
// of wrapping to 00:00 during normal counting.
module stopwatch_counter #(
  parameter int unsigned SEC_DIV = 100000000,
  parameter int unsigned ADJ_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [2:0] m10,
  output logic [3:0] m1,
  output logic [2:0] s10,
  output logic [3:0] s1,
  output logic       running
);

  localparam int unsigned SEC_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int unsigned ADJ_W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_DIV - 1);
  localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(ADJ_DIV - 1);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [SEC_W-1:0] sec_cnt;
  logic [ADJ_W-1:0] adj_cnt;
  logic             count_en_c;
  logic             sec_tick_c;
  logic             adj_tick_c;
  logic             at_max_c;
  logic [2:0]       m10_next;
  logic [3:0]       m1_next;
  logic [2:0]       s10_next;
  logic [3:0]       s1_next;

  assign count_en_c = (state == RUN) && !adj;
  assign sec_tick_c = count_en_c && (sec_cnt == SEC_LAST);
  assign adj_tick_c = adj && (adj_cnt == ADJ_LAST);
  assign at_max_c   = (m10 == 3'd5) && (m1 == 4'd9) && (s10 == 3'd5) && (s1 == 4'd9);

  // Run/pause state register; running mirrors the state it is entering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      running <= 1'b1;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  // Next state: pause pulse toggles regardless of adj; optional saturation stop.
  always_comb begin
    state_next = state;
    if (pause) begin
      state_next = (state == RUN) ? PAUSED : RUN;
    end
`ifdef STOPWATCH_SATURATE_EN
    if (sec_tick_c && at_max_c) begin
      state_next = PAUSED;
    end
`endif
  end

  // 1 Hz prescaler: advances only while counting, otherwise holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_cnt <= '0;
    end else if (count_en_c) begin
      sec_cnt <= sec_tick_c ? '0 : sec_cnt + SEC_W'(1);
    end
  end

  // 2 Hz adjust prescaler: runs while adj is high, cleared while it is low.
  always_ff @(posedge clk) begin
    if (rst || !adj) begin
      adj_cnt <= '0;
    end else begin
      adj_cnt <= adj_tick_c ? '0 : adj_cnt + ADJ_W'(1);
    end
  end

  // Next digit values: adjust steps one field mod 60, counting carries through all four.
  always_comb begin
    m10_next = m10;
    m1_next  = m1;
    s10_next = s10;
    s1_next  = s1;
    if (adj_tick_c) begin
      if (sel) begin
        if (s1 == 4'd9) begin
          s1_next  = 4'd0;
          s10_next = (s10 == 3'd5) ? 3'd0 : s10 + 3'd1;
        end else begin
          s1_next = s1 + 4'd1;
        end
      end else begin
        if (m1 == 4'd9) begin
          m1_next  = 4'd0;
          m10_next = (m10 == 3'd5) ? 3'd0 : m10 + 3'd1;
        end else begin
          m1_next = m1 + 4'd1;
        end
      end
    end else if (sec_tick_c) begin
`ifdef STOPWATCH_SATURATE_EN
      if (!at_max_c) begin
`else
      begin
`endif
        if (s1 != 4'd9) begin
          s1_next = s1 + 4'd1;
        end else begin
          s1_next = 4'd0;
          if (s10 != 3'd5) begin
            s10_next = s10 + 3'd1;
          end else begin
            s10_next = 3'd0;
            if (m1 != 4'd9) begin
              m1_next = m1 + 4'd1;
            end else begin
              m1_next  = 4'd0;
              m10_next = (m10 == 3'd5) ? 3'd0 : m10 + 3'd1;
            end
          end
        end
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      m10 <= 3'd0;
      m1  <= 4'd0;
      s10 <= 3'd0;
      s1  <= 4'd0;
    end else begin
      m10 <= m10_next;
      m1  <= m1_next;
      s10 <= s10_next;
      s1  <= s1_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed step table for stopwatch_counter with SEC_DIV=4, ADJ_DIV=2.
// Each step holds its inputs for a number of clock edges, then checks the outputs.
module tb_stopwatch_counter;

  logic       clk;
  logic       rst;
  logic       pause;
  logic       adj;
  logic       sel;
  logic [2:0] m10;
  logic [3:0] m1;
  logic [2:0] s10;
  logic [3:0] s1;
  logic       running;

  int checks;
  int failures;
  bit done;

  typedef struct {
    string      name;
    logic       rst;
    logic       pause;
    logic       adj;
    logic       sel;
    int         cycles;
    logic [2:0] m10;
    logic [3:0] m1;
    logic [2:0] s10;
    logic [3:0] s1;
    logic       running;
  } step_t;

  step_t steps[$];

  stopwatch_counter #(
    .SEC_DIV(4),
    .ADJ_DIV(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pause  (pause),
    .adj    (adj),
    .sel    (sel),
    .m10    (m10),
    .m1     (m1),
    .s10    (s10),
    .s1     (s1),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string name, input logic r, input logic p, input logic a,
                     input logic s, input int cyc, input int mm, input int ss,
                     input logic run);
    step_t st;
    st.name    = name;
    st.rst     = r;
    st.pause   = p;
    st.adj     = a;
    st.sel     = s;
    st.cycles  = cyc;
    st.m10     = 3'(mm / 10);
    st.m1      = 4'(mm % 10);
    st.s10     = 3'(ss / 10);
    st.s1      = 4'(ss % 10);
    st.running = run;
    steps.push_back(st);
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    if (!done) begin
      failures++;
      $display("FAIL timeout: step table did not complete within 100000 cycles");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    done     = 1'b0;
    rst      = 1'b1;
    pause    = 1'b0;
    adj      = 1'b0;
    sel      = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m10 !== 3'd0 || m1 !== 4'd0 || s10 !== 3'd0 || s1 !== 4'd0 ||
        running !== 1'b1 || dut.sec_cnt !== '0 || dut.adj_cnt !== '0) begin
      failures++;
      $display("FAIL reset_check: got %0d%0d:%0d%0d running=%0b sec_cnt=%0d adj_cnt=%0d",
               m10, m1, s10, s1, running, dut.sec_cnt, dut.adj_cnt);
    end

    // Basic counting from reset
    add("reset_state",     1, 0, 0, 0,  2,  0,  0, 1);
    add("first_second",    0, 0, 0, 0,  4,  0,  1, 1);
    add("ten_seconds",     0, 0, 0, 0, 36,  0, 10, 1);
    // Pause / resume around 00:03
    add("reset_a",         1, 0, 0, 0,  1,  0,  0, 1);
    add("reach_0003",      0, 0, 0, 0, 12,  0,  3, 1);
    add("pre_pause",       0, 0, 0, 0,  1,  0,  3, 1);
    add("pause_pulse",     0, 1, 0, 0,  1,  0,  3, 0);
    add("paused_hold",     0, 0, 0, 0,100,  0,  3, 0);
    add("resume_pulse",    0, 1, 0, 0,  1,  0,  3, 1);
    add("resume_plus1",    0, 0, 0, 0,  1,  0,  3, 1);
    add("resume_plus2",    0, 0, 0, 0,  1,  0,  4, 1);
    // Seconds adjust wrap from 00:58
    add("reset_b",         1, 0, 0, 0,  1,  0,  0, 1);
    add("reach_0058",      0, 0, 0, 0,232,  0, 58, 1);
    add("adj_s_edge1",     0, 0, 1, 1,  1,  0, 58, 1);
    add("adj_s_edge2",     0, 0, 1, 1,  1,  0, 59, 1);
    add("adj_s_edge3",     0, 0, 1, 1,  1,  0, 59, 1);
    add("adj_s_wrap",      0, 0, 1, 1,  1,  0,  0, 1);
    add("after_adj_s",     0, 0, 0, 0,  4,  0,  1, 1);
    // Minutes adjust wrap from 59:30, then sel switch mid-adjust
    add("reset_c",         1, 0, 0, 0,  1,  0,  0, 1);
    add("adj_m_to_59",     0, 0, 1, 0,118, 59,  0, 1);
    add("run_to_5930",     0, 0, 0, 0,120, 59, 30, 1);
    add("adj_m_edge1",     0, 0, 1, 0,  1, 59, 30, 1);
    add("adj_m_wrap",      0, 0, 1, 0,  1,  0, 30, 1);
    add("sel_sw_edge1",    0, 0, 1, 1,  1,  0, 30, 1);
    add("sel_sw_step",     0, 0, 1, 1,  1,  0, 31, 1);
    // Reset at 12:34 coinciding with a pause pulse
    add("reset_d",         1, 0, 0, 0,  1,  0,  0, 1);
    add("adj_to_1200",     0, 0, 1, 0, 24, 12,  0, 1);
    add("adj_to_1234",     0, 0, 1, 1, 68, 12, 34, 1);
    add("leave_adj",       0, 0, 0, 0,  1, 12, 34, 1);
    add("rst_with_pause",  1, 1, 0, 0,  1,  0,  0, 1);
    add("post_rst_3",      0, 0, 0, 0,  3,  0,  0, 1);
    add("post_rst_4",      0, 0, 0, 0,  1,  0,  1, 1);
    // Pause toggled during adjust takes effect after adj drops
    add("reset_e",         1, 0, 0, 0,  1,  0,  0, 1);
    add("pause_in_adj",    0, 1, 1, 1,  1,  0,  0, 0);
    add("adj_while_pause", 0, 0, 1, 1,  1,  0,  1, 0);
    add("paused_after_adj",0, 0, 0, 0,  8,  0,  1, 0);
    add("resume_e",        0, 1, 0, 0,  1,  0,  1, 1);
    add("count_after_e",   0, 0, 0, 0,  4,  0,  2, 1);
    // Pause pulse coinciding with secTick
    add("reset_f",         1, 0, 0, 0,  1,  0,  0, 1);
    add("pre_tick",        0, 0, 0, 0,  3,  0,  0, 1);
    add("pause_on_tick",   0, 1, 0, 0,  1,  0,  1, 0);
    add("resume_f",        0, 1, 0, 0,  1,  0,  1, 1);
    // Full hour rollover
    add("reset_g",         1, 0, 0, 0,  1,  0,  0, 1);
    add("reach_5959",      0, 0, 0, 0,14399, 59, 59, 1);
`ifdef STOPWATCH_SATURATE_EN
    add("saturate",        0, 0, 0, 0,  1, 59, 59, 0);
    add("sat_resume",      0, 1, 0, 0,  1, 59, 59, 1);
    add("sat_hold",        0, 0, 0, 0,  3, 59, 59, 1);
    add("sat_again",       0, 0, 0, 0,  1, 59, 59, 0);
`else
    add("rollover",        0, 0, 0, 0,  1,  0,  0, 1);
    add("after_rollover",  0, 0, 0, 0,  4,  0,  1, 1);
`endif

    foreach (steps[i]) begin
      rst   = steps[i].rst;
      pause = steps[i].pause;
      adj   = steps[i].adj;
      sel   = steps[i].sel;
      repeat (steps[i].cycles) @(posedge clk);
      @(negedge clk);
      checks++;
      if (m10 !== steps[i].m10 || m1 !== steps[i].m1 || s10 !== steps[i].s10 ||
          s1 !== steps[i].s1 || running !== steps[i].running) begin
        failures++;
        $display("FAIL %s: got %0d%0d:%0d%0d running=%0b, want %0d%0d:%0d%0d running=%0b",
                 steps[i].name, m10, m1, s10, s1, running,
                 steps[i].m10, steps[i].m1, steps[i].s10, steps[i].s1, steps[i].running);
      end
    end

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
